// File: rtl/xy_seq_pkg.sv
// Shared types and constants for the XY point sequencer: FSM encoding,
// point word field layout and default sizing.
package xy_seq_pkg;

  localparam int DEPTH_DEFAULT   = 32;
  localparam int DWELL_W_DEFAULT = 8;

  localparam int PT_W         = 16;
  localparam int PT_X_LSB     = 0;
  localparam int PT_X_W       = 8;
  localparam int PT_Y_LSB     = 8;
  localparam int PT_Y_W       = 7;
  localparam int PT_BLANK_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DWELL = 2'd2
  } seq_state_e;

  function automatic logic [PT_W-1:0] pack_point(input logic              blank,
                                                 input logic [PT_Y_W-1:0] y,
                                                 input logic [PT_X_W-1:0] x);
    logic [PT_W-1:0] p;
    p                       = '0;
    p[PT_BLANK_BIT]         = blank;
    p[PT_Y_LSB +: PT_Y_W]   = y;
    p[PT_X_LSB +: PT_X_W]   = x;
    return p;
  endfunction

endpackage

// File: rtl/xy_point_sequencer_if.sv
// Point-table write channel of the XY point sequencer.
// A write transfers on a rising edge where wr_valid and wr_ready are both high;
// the master holds wr_addr/wr_data stable while wr_valid is high and not yet accepted.
interface xy_point_sequencer_if
  import xy_seq_pkg::*;
#(
  parameter int ADDR_W = 5
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PT_W-1:0]   wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/xy_point_table.sv
// Point storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded frame survives a reset.
module xy_point_table
  import xy_seq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PT_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PT_W-1:0]   rdata
);

  logic [PT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/xy_point_sequencer.sv
// Plays a table of XY points out to registered DAC outputs, holding each point
// for a configurable dwell, with optional frame looping and abort.
module xy_point_sequencer
  import xy_seq_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  xy_point_sequencer_if.slave wr_if,
  input  logic [ADDR_W-1:0]   cfg_last,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic                cfg_loop,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic [PT_X_W-1:0]   bnc_x,
  output logic [PT_Y_W-1:0]   bnc_y,
  output logic                bnc_blank,
  output logic                bnc_trig,
  output logic                frame_done,
  output seq_state_e          dbg_state
);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;
  logic [PT_X_W-1:0]  x_d;
  logic [PT_Y_W-1:0]  y_d;
  logic               blank_d, trig_d, frame_end;
  logic [PT_W-1:0]    rd_data;

  // Reset wins over a write arriving in the same cycle.
  xy_point_table #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_table (
    .clk   (clk),
    .we    (wr_if.wr_valid & wr_if.wr_ready & ~reset),
    .waddr (wr_if.wr_addr),
    .wdata (wr_if.wr_data),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      bnc_x     <= '0;
      bnc_y     <= '0;
      bnc_blank <= 1'b1;
      bnc_trig  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      dwell_q   <= dwell_d;
      loop_q    <= loop_d;
      bnc_x     <= x_d;
      bnc_y     <= y_d;
      bnc_blank <= blank_d;
      bnc_trig  <= trig_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    loop_d    = loop_q;
    x_d       = bnc_x;
    y_d       = bnc_y;
    blank_d   = bnc_blank;
    trig_d    = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        blank_d = 1'b1;
        if (start && !stop) begin
          last_d  = cfg_last;
          dwell_d = cfg_dwell;
          loop_d  = cfg_loop;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        x_d     = rd_data[PT_X_LSB +: PT_X_W];
        y_d     = rd_data[PT_Y_LSB +: PT_Y_W];
        blank_d = rd_data[PT_BLANK_BIT];
        trig_d  = (idx_q == '0);
        cnt_d   = dwell_q;
        state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (cnt_q == '0) begin
          if (idx_q == last_q) begin
            frame_end = 1'b1;
            if (loop_q) begin
              last_d  = cfg_last;
              dwell_d = cfg_dwell;
              loop_d  = cfg_loop;
              idx_d   = '0;
              state_d = ST_FETCH;
            end else begin
              blank_d = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything above: beam off, position frozen, no pulses.
    if (stop) begin
      state_d   = ST_IDLE;
      idx_d     = idx_q;
      x_d       = bnc_x;
      y_d       = bnc_y;
      blank_d   = 1'b1;
      trig_d    = 1'b0;
      frame_end = 1'b0;
    end
  end

  assign frame_done     = frame_end;
  assign busy           = (state_q != ST_IDLE);
  assign wr_if.wr_ready = (state_q != ST_FETCH);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_xy_point_sequencer.sv
// Directed self-checking bench for xy_point_sequencer with a point scoreboard.
module tb_xy_point_sequencer;
  import xy_seq_pkg::*;

  localparam int DEPTH   = 32;
  localparam int DWELL_W = 8;
  localparam int ADDR_W  = 5;
  localparam int W       = 17;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  cfg_last;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_loop, start, stop;
  logic               busy, bnc_blank, bnc_trig, frame_done;
  logic [7:0]         bnc_x;
  logic [6:0]         bnc_y;
  seq_state_e         dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0]  exp_q[$];
  logic [15:0]   tbl[DEPTH];

  xy_point_sequencer_if #(.ADDR_W(ADDR_W)) wr_if ();

  xy_point_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_if      (wr_if),
    .cfg_last   (cfg_last),
    .cfg_dwell  (cfg_dwell),
    .cfg_loop   (cfg_loop),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .bnc_x      (bnc_x),
    .bnc_y      (bnc_y),
    .bnc_blank  (bnc_blank),
    .bnc_trig   (bnc_trig),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_point(input int a, input logic [15:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = ADDR_W'(a);
    wr_if.wr_data  = d;
    #1;
    chk("wr_ready_idle", wr_if.wr_ready, 1);
    tick();
    wr_if.wr_valid = 1'b0;
    tbl[a] = d;
  endtask

  // expected point word: {trig, blank, y, x}
  task automatic push_pt(input int i);
    exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, tbl[i]});
  endtask

  // Entered in a FETCH cycle; leaves on the cycle after the last point's dwell.
  task automatic run_frame(input int npts, input int dwell, input int upd_k, input logic [15:0] upd_data);
    logic [W-1:0] e;
    for (int k = 0; k < npts; k++) begin
      chk("fetch_wr_ready", wr_if.wr_ready, 0);
      chk("fetch_busy", busy, 1);
      tick();
      chk("sb_nonempty", exp_q.size() != 0, 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk("point", {bnc_trig, bnc_blank, bnc_y, bnc_x}, e);
      if (k == upd_k) begin
        wr_if.wr_data = upd_data;
        tbl[wr_if.wr_addr] = upd_data;
      end
      for (int j = 0; j <= dwell; j++) begin
        if (j > 0) tick();
        chk("dwell_trig", bnc_trig, (j == 0) ? e[16] : 1'b0);
        chk("frame_done", frame_done, (k == npts - 1) && (j == dwell));
        chk("dwell_busy", busy, 1);
        chk("dwell_wr_ready", wr_if.wr_ready, 1);
      end
      chk("point_hold", {bnc_blank, bnc_y, bnc_x}, e[15:0]);
      tick();
    end
  endtask

  initial begin
    logic [W-1:0] e;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_last = '0; cfg_dwell = '0; cfg_loop = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    repeat (3) tick();
    chk("rst_x", bnc_x, 0);
    chk("rst_y", bnc_y, 0);
    chk("rst_blank", bnc_blank, 1);
    chk("rst_trig", bnc_trig, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_if.wr_ready, 1);
    chk("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();

    // single 4-point frame, dwell 2
    wr_point(0, pack_point(1'b0, 7'h10, 8'h20));
    wr_point(1, pack_point(1'b0, 7'h21, 8'h43));
    wr_point(2, pack_point(1'b1, 7'h32, 8'h65));
    wr_point(3, pack_point(1'b0, 7'h7f, 8'hff));
    cfg_last = 3; cfg_dwell = 2; cfg_loop = 1'b0;
    for (int i = 0; i < 4; i++) push_pt(i);
    start = 1'b1; tick(); start = 1'b0;
    run_frame(4, 2, -1, '0);
    chk("f1_idle_busy", busy, 0);
    chk("f1_idle_blank", bnc_blank, 1);
    chk("f1_idle_xy", {bnc_y, bnc_x}, tbl[3][14:0]);
    chk("f1_idle_trig", bnc_trig, 0);
    chk("f1_sb_drained", exp_q.size(), 0);

    // one point looping, dwell 0
    cfg_last = 0; cfg_dwell = 0; cfg_loop = 1'b1;
    push_pt(0);
    start = 1'b1; tick(); start = 1'b0;
    run_frame(1, 0, -1, '0);
    repeat (2) begin
      push_pt(0);
      run_frame(1, 0, -1, '0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_fetch_busy", busy, 0);
    chk("stop_fetch_blank", bnc_blank, 1);
    chk("stop_fetch_trig", bnc_trig, 0);
    chk("stop_fetch_xy", {bnc_y, bnc_x}, tbl[0][14:0]);

    // stop and start together at the frame-end cycle
    cfg_last = 0; cfg_dwell = 2; cfg_loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("ss_trig", bnc_trig, 1);
    tick(); tick();
    stop = 1'b1; start = 1'b1; #1;
    chk("ss_frame_done_suppressed", frame_done, 0);
    tick(); stop = 1'b0; start = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_blank", bnc_blank, 1);
    chk("ss_trig_off", bnc_trig, 0);
    chk("ss_xy_hold", {bnc_y, bnc_x}, tbl[0][14:0]);
    tick();
    chk("ss_still_idle", busy, 0);

    // writes held during looping playback; entry 2 changes while shown
    cfg_last = 3; cfg_dwell = 1; cfg_loop = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 2; wr_if.wr_data = tbl[2];
    for (int i = 0; i < 4; i++) push_pt(i);
    start = 1'b1; tick();
    run_frame(4, 1, 2, pack_point(1'b0, 7'h55, 8'haa));
    for (int i = 0; i < 4; i++) push_pt(i);
    run_frame(4, 1, -1, '0);
    stop = 1'b1; start = 1'b0; wr_if.wr_valid = 1'b0;
    tick(); stop = 1'b0;
    chk("wr_stop_busy", busy, 0);

    // full table, maximum dwell, wrap back to point 0
    for (int i = 0; i < DEPTH; i++) wr_point(i, 16'($urandom_range(0, 65535)));
    cfg_last = 31; cfg_dwell = 255; cfg_loop = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_pt(i);
    start = 1'b1; tick(); start = 1'b0;
    run_frame(32, 255, -1, '0);
    push_pt(0);
    chk("wrap_fetch", wr_if.wr_ready, 0);
    tick();
    e = exp_q.pop_front();
    chk("wrap_point", {bnc_trig, bnc_blank, bnc_y, bnc_x}, e);
    stop = 1'b1; tick(); stop = 1'b0;

    // reset mid-dwell with competing start and write
    cfg_last = 1; cfg_dwell = 2; cfg_loop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("rd_in_dwell", busy, 1);
    tick();
    reset = 1'b1; start = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 1; wr_if.wr_data = ~tbl[1];
    tick();
    reset = 1'b0; start = 1'b0; wr_if.wr_valid = 1'b0;
    chk("rd_x", bnc_x, 0);
    chk("rd_y", bnc_y, 0);
    chk("rd_blank", bnc_blank, 1);
    chk("rd_trig", bnc_trig, 0);
    chk("rd_frame_done", frame_done, 0);
    chk("rd_busy", busy, 0);
    chk("rd_wr_ready", wr_if.wr_ready, 1);
    chk("rd_state", dbg_state, ST_IDLE);
    cfg_dwell = 0;
    push_pt(0); push_pt(1);
    start = 1'b1; tick(); start = 1'b0;
    run_frame(2, 0, -1, '0);
    chk("rd_end_busy", busy, 0);
    chk("rd_end_blank", bnc_blank, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
